// File: rtl/xrv_mdu_pkg.sv
// Shared types and constants for the RV32M sequencer and its iterative divider.
package xrv_mdu_pkg;

    localparam int XLEN      = 32;
    localparam int RD_W      = 5;
    localparam int DIV_ITERS = 32;
    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_WAIT,
        S_MUL_DRAIN,
        S_DIV_RUN,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        DV_IDLE,
        DV_SETUP,
        DV_ITER,
        DV_FIX
    } div_phase_e;

endpackage

// File: rtl/xrv_mdu_seq_div.sv
// Restoring 32-bit divider: one setup cycle, 32 iterations, one sign-fixup cycle.
// Zero divisor and signed overflow finish in the setup cycle.
module xrv_div
    import xrv_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rstb,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [1:0]      funct3,
    output logic            done,
    output logic [XLEN-1:0] result
);

    div_phase_e      phase_q, phase_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [1:0]      fn_q, fn_d;
    logic [XLEN-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
    logic [5:0]      cnt_q, cnt_d;

    logic            is_signed, want_rem, div_zero, ovf;
    logic [XLEN-1:0] mag_a, mag_b, q_fix, r_fix;
    logic [XLEN:0]   rem_sh, diff;

    always_comb begin
        is_signed = ~fn_q[0];
        want_rem  = fn_q[1];
        mag_a     = (is_signed && a_q[XLEN-1]) ? -a_q : a_q;
        mag_b     = (is_signed && b_q[XLEN-1]) ? -b_q : b_q;
        div_zero  = (b_q == '0);
        ovf       = is_signed && (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
        // dvd_q shifts the dividend out of its top while quotient bits enter at the bottom
        rem_sh    = {rem_q, dvd_q[XLEN-1]};
        diff      = rem_sh - {1'b0, dvs_q};
        q_fix     = (is_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -dvd_q : dvd_q;
        r_fix     = (is_signed && a_q[XLEN-1]) ? -rem_q : rem_q;
    end

    always_comb begin
        phase_d = phase_q;
        a_d     = a_q;
        b_d     = b_q;
        fn_d    = fn_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        done    = 1'b0;
        result  = '0;
        case (phase_q)
            DV_SETUP: begin
                if (div_zero) begin
                    done    = 1'b1;
                    result  = want_rem ? a_q : DIV_BY_ZERO_Q;
                    phase_d = DV_IDLE;
                end else if (ovf) begin
                    done    = 1'b1;
                    result  = want_rem ? '0 : 32'h8000_0000;
                    phase_d = DV_IDLE;
                end else begin
                    dvd_d   = mag_a;
                    dvs_d   = mag_b;
                    rem_d   = '0;
                    cnt_d   = 6'(DIV_ITERS - 1);
                    phase_d = DV_ITER;
                end
            end
            DV_ITER: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    dvd_d = {dvd_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == '0) phase_d = DV_FIX;
            end
            DV_FIX: begin
                done    = 1'b1;
                result  = want_rem ? r_fix : q_fix;
                phase_d = DV_IDLE;
            end
            default: ;
        endcase
        if (start) begin
            a_d     = a;
            b_d     = b;
            fn_d    = funct3;
            phase_d = DV_SETUP;
        end
        if (abort) phase_d = DV_IDLE;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            phase_q <= DV_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fn_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fn_q    <= fn_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/xrv_mdu_seq.sv
// RV32M sequencer: launches the external 2-cycle multiplier or the internal divider,
// one op at a time, and holds the tagged result until writeback takes it.
//   state       | meaning
//   S_IDLE      | ready for a new op
//   S_MUL_WAIT  | multiplier launched, waiting for its strobe
//   S_MUL_DRAIN | flushed multiply, swallow its late result before reuse
//   S_DIV_RUN   | divider busy
//   S_DONE      | result held for writeback
module xrv_mdu_seq
    import xrv_mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rstb,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [2:0]      op_funct3,
    input  logic [RD_W-1:0] op_rd,
    input  logic            flush,
    output logic [XLEN-1:0] mult_a,
    output logic [XLEN-1:0] mult_b,
    output logic [2:0]      mult_optype,
    output logic            mult_valid,
    input  logic [XLEN-1:0] mult_result,
    input  logic            mult_result_valid,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data
);

    state_e          state_q, state_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0] data_q, data_d, ma_q, ma_d, mb_q, mb_d;
    logic [2:0]      mop_q, mop_d;
    logic            mv_q, mv_d;
    logic            div_start, div_abort, div_done;
    logic [XLEN-1:0] div_result;

    // rstb gates op_ready so every output reads 0 while reset is held
    assign op_ready    = rstb && (state_q == S_IDLE) && !flush;
    assign wb_valid    = (state_q == S_DONE);
    assign wb_rd       = rd_q;
    assign wb_data     = data_q;
    assign mult_a      = ma_q;
    assign mult_b      = mb_q;
    assign mult_optype = mop_q;
    assign mult_valid  = mv_q;

    always_comb begin
        state_d   = state_q;
        rd_d      = rd_q;
        data_d    = data_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        mop_d     = mop_q;
        mv_d      = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready) begin
                    rd_d = op_rd;
                    if (!op_funct3[2]) begin
                        ma_d    = op_a;
                        mb_d    = op_b;
                        mop_d   = op_funct3;
                        mv_d    = 1'b1;
                        state_d = S_MUL_WAIT;
                    end else begin
                        div_start = 1'b1;
                        state_d   = S_DIV_RUN;
                    end
                end
            end
            S_MUL_WAIT: begin
                if (flush) begin
                    state_d = mult_result_valid ? S_IDLE : S_MUL_DRAIN;
                end else if (mult_result_valid) begin
                    data_d  = mult_result;
                    state_d = S_DONE;
                end
            end
            S_MUL_DRAIN: begin
                if (mult_result_valid) state_d = S_IDLE;
            end
            S_DIV_RUN: begin
                if (flush) begin
                    div_abort = 1'b1;
                    state_d   = S_IDLE;
                end else if (div_done) begin
                    data_d  = div_result;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (wb_ready || flush) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= S_IDLE;
            rd_q    <= '0;
            data_q  <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            mop_q   <= '0;
            mv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            mop_q   <= mop_d;
            mv_q    <= mv_d;
        end
    end

    xrv_div u_div (
        .clk    (clk),
        .rstb   (rstb),
        .start  (div_start),
        .abort  (div_abort),
        .a      (op_a),
        .b      (op_b),
        .funct3 (op_funct3[1:0]),
        .done   (div_done),
        .result (div_result)
    );

endmodule
